// File: rtl/mpu_matrix_loader.sv
// Byte-stream loader for the MPU determinant stage: assembles a zero-padded 5x5 8-bit matrix
// and holds it, with its size, until the consumer acknowledges it.
module mpu_matrix_loader (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   size_in,
  input  logic [7:0]   data_in,
  input  logic         data_valid,
  output logic         data_ready,
  output logic [199:0] matrix,
  output logic [7:0]   size,
  output logic         matrix_valid,
  input  logic         matrix_ready,
  output logic         busy,
  output logic         error
);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e       state_q, state_d;
  logic [2:0]   row_q, row_d;
  logic [2:0]   col_q, col_d;
  logic [7:0]   size_q, size_d;
  logic [199:0] matrix_q, matrix_d;
  logic         error_q, error_d;

  logic         size_legal;
  logic         last_col;
  logic         last_row;
  logic [4:0]   elem_idx;

  assign size_legal = (size_in >= 8'd1) && (size_in <= 8'd5);
  assign last_col   = (col_q == size_q[2:0] - 3'd1);
  assign last_row   = (row_q == size_q[2:0] - 3'd1);
  // Column-major packing: element (row,col) lives at byte row + 5*col.
  assign elem_idx   = 5'(row_q) + 5'(col_q) * 5'd5;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    size_d   = size_q;
    matrix_d = matrix_q;
    error_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (size_legal) begin
            size_d   = size_in;
            matrix_d = '0;
            row_d    = 3'd0;
            col_d    = 3'd0;
            state_d  = StLoad;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (data_valid) begin
          matrix_d[{elem_idx, 3'b000} +: 8] = data_in;
          if (last_col) begin
            col_d = 3'd0;
            if (last_row) begin
              row_d   = 3'd0;
              state_d = StHold;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      StHold: begin
        if (matrix_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      size_q   <= 8'd0;
      matrix_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      size_q   <= size_d;
      matrix_q <= matrix_d;
      error_q  <= error_d;
    end
  end

  assign data_ready   = (state_q == StLoad);
  assign matrix_valid = (state_q == StHold);
  assign busy         = (state_q != StIdle);
  assign error        = error_q;
  assign size         = size_q;
  assign matrix       = matrix_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Scoreboard bench for mpu_matrix_loader: expected matrices are queued when a load starts and
// compared when matrix_valid is presented.
module tb_mpu_matrix_loader;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   size_in;
  logic [7:0]   data_in;
  logic         data_valid;
  logic         data_ready;
  logic [199:0] matrix;
  logic [7:0]   size;
  logic         matrix_valid;
  logic         matrix_ready;
  logic         busy;
  logic         error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [199:0] exp_mat_q[$];
  logic [7:0]   exp_size_q[$];

  mpu_matrix_loader dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .size_in      (size_in),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .matrix       (matrix),
    .size         (size),
    .matrix_valid (matrix_valid),
    .matrix_ready (matrix_ready),
    .busy         (busy),
    .error        (error)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Row-major stream base, base+1, ... placed at element (i,j) = bits 8*(i+5*j).
  function automatic logic [199:0] model_matrix(input int sz, input int base);
    logic [199:0] m;
    m = '0;
    for (int i = 0; i < sz; i++)
      for (int j = 0; j < sz; j++)
        m[8*(i+5*j) +: 8] = 8'(base + i*sz + j);
    return m;
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Starts a load, streams sz*sz bytes (optional gap every gap_every cycles), returns with
  // matrix_valid expected high and the expected result queued.
  task automatic load_stream(input string name, input int sz, input int base,
                             input int gap_every, input bit poke_start,
                             output int ready_cnt);
    int k;
    int cyc;
    bit acc;
    exp_mat_q.push_back(model_matrix(sz, base));
    exp_size_q.push_back(8'(sz));
    size_in = 8'(sz);
    start   = 1'b1;
    step();
    start = 1'b0;
    chk({name, " ready_after_start"}, 200'(data_ready), 200'(1));
    chk({name, " busy_in_load"}, 200'(busy), 200'(1));
    k = 0;
    cyc = 0;
    ready_cnt = 0;
    while (k < sz*sz && cyc < 400) begin
      if (gap_every != 0 && (cyc % gap_every) == gap_every - 1) begin
        data_valid = 1'b0;
      end else begin
        data_valid = 1'b1;
        data_in    = 8'(base + k);
      end
      if (poke_start) begin
        start   = 1'b1;
        size_in = 8'd2;
      end
      chk({name, " no_early_valid"}, 200'(matrix_valid), 200'(0));
      if (data_ready) ready_cnt++;
      acc = data_valid && data_ready;
      step();
      if (acc) k++;
      cyc++;
    end
    data_valid = 1'b0;
    start      = 1'b0;
    n_tests++;
    if (k != sz*sz) begin
      n_fail++;
      $display("FAIL %s load_timeout: accepted %0d required %0d", name, k, sz*sz);
    end
    chk({name, " valid_after_last"}, 200'(matrix_valid), 200'(1));
    chk({name, " ready_low_hold"}, 200'(data_ready), 200'(0));
  endtask

  task automatic check_output(input string name, output logic [199:0] exp_m);
    logic [7:0] exp_s;
    n_tests++;
    if (exp_mat_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty: got 0 entries required 1", name);
      exp_m = 'x;
    end else begin
      exp_m = exp_mat_q.pop_front();
      exp_s = exp_size_q.pop_front();
      chk({name, " matrix"}, matrix, exp_m);
      chk({name, " size"}, 200'(size), 200'(exp_s));
    end
  endtask

  task automatic handshake(input string name);
    matrix_ready = 1'b1;
    step();
    matrix_ready = 1'b0;
    chk({name, " valid_low_after_ack"}, 200'(matrix_valid), 200'(0));
    chk({name, " busy_low_after_ack"}, 200'(busy), 200'(0));
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0; size_in = 8'd0; data_in = 8'd0; data_valid = 1'b0; matrix_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset matrix", matrix, '0);
    chk("reset size", 200'(size), 200'(0));
    chk("reset flags", 200'({matrix_valid, data_ready, busy, error}), 200'(0));
  endtask

  task automatic test_load_2x2();
    int rc;
    logic [199:0] m;
    load_stream("2x2", 2, 1, 0, 1'b0, rc);
    chk("2x2 ready_cycles", 200'(rc), 200'(4));
    check_output("2x2", m);
    chk("2x2 at00", 200'(matrix[7:0]), 200'(1));
    chk("2x2 at01", 200'(matrix[47:40]), 200'(2));
    chk("2x2 at10", 200'(matrix[15:8]), 200'(3));
    handshake("2x2");
  endtask

  task automatic test_load_5x5_gaps();
    int rc;
    logic [199:0] m;
    load_stream("5x5", 5, 1, 3, 1'b1, rc);
    chk("5x5 size_not_poked", 200'(size), 200'(5));
    check_output("5x5", m);
    chk("5x5 at42", 200'(matrix[8*(4+5*2) +: 8]), 200'(1 + 5*4 + 2));
    handshake("5x5");
  endtask

  task automatic test_backpressure();
    int rc;
    logic [199:0] m;
    load_stream("bp", 3, 10, 0, 1'b0, rc);
    check_output("bp", m);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp hold_matrix", matrix, m);
      chk("bp hold_size", 200'(size), 200'(3));
      chk("bp hold_valid", 200'(matrix_valid), 200'(1));
    end
    handshake("bp");
    chk("bp retained", matrix, m);
  endtask

  task automatic test_illegal_sizes();
    logic [199:0] m;
    logic [7:0] bad[2];
    m = model_matrix(3, 10);
    bad[0] = 8'd0;
    bad[1] = 8'd6;
    for (int b = 0; b < 2; b++) begin
      chk("ill error_idle", 200'(error), 200'(0));
      size_in = bad[b];
      start   = 1'b1;
      step();
      start = 1'b0;
      chk("ill error_pulse", 200'(error), 200'(1));
      chk("ill busy", 200'(busy), 200'(0));
      chk("ill ready", 200'(data_ready), 200'(0));
      chk("ill matrix_kept", matrix, m);
      chk("ill size_kept", 200'(size), 200'(3));
      step();
      chk("ill error_cleared", 200'(error), 200'(0));
      chk("ill still_idle", 200'(busy), 200'(0));
    end
  endtask

  task automatic test_reset_mid_load();
    int rc;
    logic [199:0] m;
    size_in = 8'd4;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      data_valid = 1'b1;
      data_in    = 8'(1 + k);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    data_valid = 1'b0;
    chk("rml matrix", matrix, '0);
    chk("rml size", 200'(size), 200'(0));
    chk("rml flags", 200'({matrix_valid, data_ready, busy, error}), 200'(0));
    load_stream("1x1", 1, 9, 0, 1'b0, rc);
    check_output("1x1", m);
    chk("1x1 at00", 200'(matrix[7:0]), 200'(9));
    handshake("1x1");
  endtask

  initial begin
    test_reset();
    test_load_2x2();
    test_load_5x5_gaps();
    test_backpressure();
    test_illegal_sizes();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
